// File: rtl/dp_action_pkg.sv
// Shared types and action-word decode for the action executor stage.
package dp_action_pkg;

   localparam logic [3:0] OP_DROP = 4'd1;
   localparam logic [3:0] OP_FWD  = 4'd2;
   localparam logic [3:0] OP_CPU  = 4'd3;

   localparam int unsigned OPC_LSB  = 0;
   localparam int unsigned PORT_LSB = 8;

   typedef enum logic [1:0] {S_WAIT, S_FWD, S_DROP} state_e;

   typedef enum logic [1:0] {OUT_DROP, OUT_FWD, OUT_CPU} outcome_e;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } fifo_entry_t;

   typedef struct packed {
      outcome_e   outcome;
      logic [3:0] port;
   } decision_t;

   // Unknown opcodes fall back to DROP so they land in drop_count.
   function automatic decision_t decode_action(input logic [63:0] act,
                                               input logic [3:0]  cpu_port);
      decision_t d;
      d.port = act[PORT_LSB +: 4];
      case (act[OPC_LSB +: 4])
         OP_FWD:  d.outcome = OUT_FWD;
         OP_CPU:  begin
            d.outcome = OUT_CPU;
            d.port    = cpu_port;
         end
         default: d.outcome = OUT_DROP;
      endcase
      return d;
   endfunction

   function automatic state_e target_state(input outcome_e oc);
      return (oc == OUT_DROP) ? S_DROP : S_FWD;
   endfunction

endpackage

// File: rtl/pkt_byte_fifo.sv
// First-word fall-through byte FIFO holding {last, data}; DEPTH must be a power of 2.
module pkt_byte_fifo
   import dp_action_pkg::*;
#(
   parameter int unsigned DEPTH = 128
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  fifo_entry_t              wdata,
   input  logic                     pop,
   output fifo_entry_t              rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   fifo_entry_t     mem [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q;
   logic            do_push, do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Pointers are exactly AW bits wide, so increment wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/action_executor.sv
// Buffers ingress packets, applies the per-packet action word, and emits the egress stream.
module action_executor
   import dp_action_pkg::*;
#(
   parameter int unsigned DEPTH       = 128,
   parameter logic [3:0]  CPU_PORT    = 4'hF,
   parameter logic [63:0] MISS_ACTION = 64'h0000_0000_0000_0002
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        rx_last,
   output logic        rx_ready,
   input  logic        dec_valid,
   input  logic        dec_hit,
   input  logic [63:0] dec_action,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_last,
   output logic [3:0]  tx_port,
   input  logic        tx_ready,
   output logic [31:0] fwd_count,
   output logic [31:0] cpu_count,
   output logic [31:0] drop_count,
   output logic        dec_overrun
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fifo_entry_t   head;
   logic [CW-1:0] fifo_count;
   logic          fifo_full, fifo_empty;
   logic          push, pop, pop_last, consume_pend, take_direct;
   decision_t     dec_d;

   state_e        state_q;
   outcome_e      cur_q;
   decision_t     pend_q;
   logic          pend_valid_q;
   logic [3:0]    tx_port_q;
   logic [31:0]   fwd_q, cpu_q, drop_q;
   logic          overrun_q;

   pkt_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({rx_last, rx_data}),
      .pop   (pop),
      .rdata (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign rx_ready = ~fifo_full;
   assign push     = rx_valid & rx_ready;
   assign dec_d    = decode_action(dec_hit ? dec_action : MISS_ACTION, CPU_PORT);

   assign tx_valid = (state_q == S_FWD) & ~fifo_empty;
   assign pop      = ~fifo_empty & (((state_q == S_FWD) & tx_ready) | (state_q == S_DROP));
   assign pop_last = pop & head.last;
   assign tx_data  = tx_valid ? head.data : 8'h00;
   assign tx_last  = tx_valid & head.last;
   assign tx_port  = tx_port_q;

   // The pending slot frees on the same edge it is consumed, so a new decision may refill it.
   assign consume_pend = pend_valid_q & ((state_q == S_WAIT) | pop_last);
   assign take_direct  = dec_valid & (state_q == S_WAIT) & ~pend_valid_q;

   assign fwd_count   = fwd_q;
   assign cpu_count   = cpu_q;
   assign drop_count  = drop_q;
   assign dec_overrun = overrun_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_WAIT;
         cur_q        <= OUT_DROP;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         tx_port_q    <= 4'h0;
         fwd_q        <= '0;
         cpu_q        <= '0;
         drop_q       <= '0;
         overrun_q    <= 1'b0;
      end else begin
         unique case (state_q)
            S_WAIT: begin
               if (pend_valid_q) begin
                  state_q   <= target_state(pend_q.outcome);
                  cur_q     <= pend_q.outcome;
                  tx_port_q <= pend_q.port;
               end else if (dec_valid) begin
                  state_q   <= target_state(dec_d.outcome);
                  cur_q     <= dec_d.outcome;
                  tx_port_q <= dec_d.port;
               end
            end
            S_FWD, S_DROP: begin
               if (pop_last) begin
                  unique case (cur_q)
                     OUT_FWD: fwd_q  <= fwd_q + 32'd1;
                     OUT_CPU: cpu_q  <= cpu_q + 32'd1;
                     default: drop_q <= drop_q + 32'd1;
                  endcase
                  if (pend_valid_q) begin
                     state_q   <= target_state(pend_q.outcome);
                     cur_q     <= pend_q.outcome;
                     tx_port_q <= pend_q.port;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
            end
            default: state_q <= S_WAIT;
         endcase

         if (dec_valid && !take_direct) begin
            if (pend_valid_q && !consume_pend) begin
               overrun_q <= 1'b1;
            end else begin
               pend_q       <= dec_d;
               pend_valid_q <= 1'b1;
            end
         end else if (consume_pend) begin
            pend_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_action_executor.sv
// Directed bench for action_executor: forward, drop, miss, CPU, backpressure, back-to-back, reset.
module tb_action_executor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_valid, rx_last, rx_ready;
   logic [7:0]  rx_data;
   logic        dec_valid, dec_hit;
   logic [63:0] dec_action;
   logic        tx_valid, tx_last, tx_ready;
   logic [7:0]  tx_data;
   logic [3:0]  tx_port;
   logic [31:0] fwd_count, cpu_count, drop_count;
   logic        dec_overrun;

   always #5 clk = ~clk;

   action_executor #(
      .DEPTH       (128),
      .CPU_PORT    (4'hF),
      .MISS_ACTION (64'h2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .rx_last     (rx_last),
      .rx_ready    (rx_ready),
      .dec_valid   (dec_valid),
      .dec_hit     (dec_hit),
      .dec_action  (dec_action),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_last     (tx_last),
      .tx_port     (tx_port),
      .tx_ready    (tx_ready),
      .fwd_count   (fwd_count),
      .cpu_count   (cpu_count),
      .drop_count  (drop_count),
      .dec_overrun (dec_overrun)
   );

   typedef struct {
      logic [7:0] data;
      logic       last;
      logic [3:0] port;
      int         cyc;
   } beat_t;

   beat_t      log_q[$];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         tx_valid_cycles = 0;
   int         rx_accepted = 0;
   int         exp_fwd = 0, exp_cpu = 0, exp_drop = 0;
   logic       stall_q = 1'b0;
   logic [8:0] stall_val = '0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Egress monitor at the falling edge; inputs change only just after the rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_q = 1'b0;
      end else begin
         if (tx_valid) tx_valid_cycles++;
         if (stall_q) begin
            check_eq("hold_valid", tx_valid, 1);
            check_eq("hold_data", {tx_last, tx_data}, stall_val);
         end
         stall_q   = tx_valid && !tx_ready;
         stall_val = {tx_last, tx_data};
         if (tx_valid && tx_ready) log_q.push_back('{tx_data, tx_last, tx_port, cyc});
      end
   end

   function automatic logic [7:0] pkt_byte(input int p, input int i, input int len);
      logic [7:0] b;
      b = 8'(p * 37 + i);
      if (i == 0) b = 8'hAA;
      else if (i == len - 1) b = 8'h00;
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pkt(input int p, input int len, input int n_send);
      logic acc;
      for (int i = 0; i < n_send; i++) begin
         rx_valid = 1'b1;
         rx_data  = pkt_byte(p, i, len);
         rx_last  = (i == len - 1);
         acc      = 1'b0;
         for (int k = 0; k < 2000 && !acc; k++) begin
            @(negedge clk);
            acc = rx_ready;
            if (acc) rx_accepted++;
            tick();
         end
         if (!acc) check_eq("rx_stall_timeout", 0, 1);
      end
      rx_valid = 1'b0;
      rx_last  = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic send_dec(input logic hit, input logic [63:0] act);
      dec_valid  = 1'b1;
      dec_hit    = hit;
      dec_action = act;
      tick();
      dec_valid  = 1'b0;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 3000; k++) begin
         if (int'(fwd_count) == exp_fwd && int'(cpu_count) == exp_cpu &&
             int'(drop_count) == exp_drop) break;
         tick();
      end
      repeat (3) tick();
      check_eq("fwd_count", fwd_count, exp_fwd);
      check_eq("cpu_count", cpu_count, exp_cpu);
      check_eq("drop_count", drop_count, exp_drop);
      check_eq("fifo_empty_after", dut.fifo_count, 0);
   endtask

   task automatic check_pkt(input string tag, input int p, input int len,
                            input logic [3:0] port, input int base);
      for (int i = 0; i < len; i++) begin
         if (base + i < log_q.size()) begin
            check_eq({tag, "_data"}, log_q[base+i].data, pkt_byte(p, i, len));
            check_eq({tag, "_last"}, log_q[base+i].last, (i == len - 1));
            check_eq({tag, "_port"}, log_q[base+i].port, port);
         end
      end
   endtask

   // outcome: 0 drop, 1 forward, 2 cpu
   task automatic run_pkt(input string tag, input int p, input int len, input logic hit,
                          input logic [63:0] act, input logic [3:0] port, input int outcome);
      log_q.delete();
      tx_valid_cycles = 0;
      tx_ready = 1'b1;
      drive_pkt(p, len, len);
      send_dec(hit, act);
      if (outcome == 0) exp_drop++;
      else if (outcome == 1) exp_fwd++;
      else exp_cpu++;
      wait_done();
      if (outcome == 0) begin
         check_eq({tag, "_beats"}, log_q.size(), 0);
         check_eq({tag, "_txvalid_cycles"}, tx_valid_cycles, 0);
      end else begin
         check_eq({tag, "_beats"}, log_q.size(), len);
         check_pkt(tag, p, len, port, 0);
      end
   endtask

   initial begin
      rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_last = 1'b0;
      dec_valid = 1'b0; dec_hit = 1'b0; dec_action = '0; tx_ready = 1'b1;
      repeat (2) tick();
      check_eq("rst_tx_valid", tx_valid, 0);
      check_eq("rst_tx_data", tx_data, 0);
      check_eq("rst_tx_last", tx_last, 0);
      check_eq("rst_tx_port", tx_port, 0);
      check_eq("rst_rx_ready", rx_ready, 1);
      check_eq("rst_overrun", dec_overrun, 0);
      check_eq("rst_counts", {fwd_count, cpu_count} | drop_count, 0);
      rst_n = 1'b1;
      tick();

      run_pkt("fwd", 1, 54, 1'b1, 64'h0302, 4'h3, 1);
      run_pkt("drop", 2, 54, 1'b1, 64'h1, 4'h0, 0);
      run_pkt("drop_op7", 3, 54, 1'b1, 64'h7, 4'h0, 0);
      run_pkt("miss", 4, 54, 1'b0, 64'h0302, 4'h0, 1);
      run_pkt("cpu", 5, 54, 1'b1, 64'h3, 4'hF, 2);

      // Backpressure: decision held back until the FIFO fills.
      log_q.delete();
      rx_accepted = 0;
      fork
         drive_pkt(6, 200, 200);
         begin
            for (int k = 0; k < 1000; k++) begin
               @(negedge clk);
               if (!rx_ready) break;
            end
            check_eq("bp_accepted_at_full", rx_accepted, 128);
            check_eq("bp_fifo_count", dut.fifo_count, 128);
            @(posedge clk);
            #1;
            send_dec(1'b1, 64'h0502);
         end
         begin
            for (int k = 0; k < 3000 && log_q.size() < 200; k++) begin
               tx_ready = ~tx_ready;
               tick();
            end
            tx_ready = 1'b1;
         end
      join
      exp_fwd++;
      wait_done();
      check_eq("bp_beats", log_q.size(), 200);
      check_pkt("bp", 6, 200, 4'h5, 0);

      // Back-to-back with a pending decision, then an overrunning third decision.
      log_q.delete();
      drive_pkt(7, 20, 20);
      drive_pkt(8, 15, 15);
      send_dec(1'b1, 64'h0102);
      send_dec(1'b1, 64'h0202);
      send_dec(1'b1, 64'h0402);
      exp_fwd += 2;
      wait_done();
      check_eq("b2b_overrun", dec_overrun, 1);
      check_eq("b2b_beats", log_q.size(), 35);
      check_pkt("b2b_a", 7, 20, 4'h1, 0);
      check_pkt("b2b_b", 8, 15, 4'h2, 20);
      if (log_q.size() > 20) check_eq("b2b_gap", log_q[20].cyc - log_q[19].cyc, 1);

      // Asynchronous reset in the middle of a forwarded packet.
      log_q.delete();
      tx_ready = 1'b1;
      send_dec(1'b1, 64'h0602);
      drive_pkt(9, 54, 20);
      #2 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_tx_valid", tx_valid, 0);
      check_eq("mid_rst_tx_data", tx_data, 0);
      check_eq("mid_rst_tx_last", tx_last, 0);
      check_eq("mid_rst_tx_port", tx_port, 0);
      check_eq("mid_rst_rx_ready", rx_ready, 1);
      check_eq("mid_rst_overrun", dec_overrun, 0);
      check_eq("mid_rst_fwd_count", fwd_count, 0);
      exp_fwd = 0; exp_cpu = 0; exp_drop = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      run_pkt("post_rst", 10, 54, 1'b1, 64'h0302, 4'h3, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
